// File: rtl/btn_conditioner.sv
// Four independent push-button conditioners: two-flop synchronizer, counting debouncer,
// press/release edge pulses and a per-button auto-repeat generator.
module btn_conditioner #(
  parameter int DEB_CYCLES = 4,
  parameter int REP_DELAY  = 32,
  parameter int REP_RATE   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  input  logic [3:0] rep_en,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic [3:0] btn_rep,
  output logic       any_press
);

  localparam logic [15:0] DEB_LAST   = 16'(DEB_CYCLES - 1);
  localparam logic [15:0] DELAY_LAST = 16'(REP_DELAY - 1);
  localparam logic [15:0] RATE_LAST  = 16'(REP_RATE - 1);
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2,
    HELD   = 2'd3
  } rep_state_t;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic [1:0]  sync_reg;
      logic        level_reg;
      logic [15:0] deb_cnt_reg;
      logic        press_reg;
      logic        release_reg;
      logic        rep_reg;
      logic [15:0] rep_cnt_reg;
      rep_state_t  state_reg;

      logic        sample;
      logic        deb_done;
      logic        rise;
      logic        fall;

      // Raw input is active-low; the synchronized sample is flipped to active-high.
      assign sample   = ~sync_reg[1];
      assign deb_done = (sample != level_reg) && (deb_cnt_reg == DEB_LAST);
      assign rise     = deb_done && sample;
      assign fall     = deb_done && !sample;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg    <= 2'b11;
          level_reg   <= 1'b0;
          deb_cnt_reg <= 16'd0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
        end else begin
          sync_reg    <= {sync_reg[0], btn[gi]};
          press_reg   <= rise;
          release_reg <= fall;
          if (sample == level_reg) begin
            deb_cnt_reg <= 16'd0;
          end else if (deb_done) begin
            level_reg   <= sample;
            deb_cnt_reg <= 16'd0;
          end else if (deb_cnt_reg != CNT_MAX) begin
            deb_cnt_reg <= deb_cnt_reg + 16'd1;
          end
        end
      end

      // Release overrides everything, so a repeat due on the release edge is dropped.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg   <= IDLE;
          rep_cnt_reg <= 16'd0;
          rep_reg     <= 1'b0;
        end else begin
          rep_reg <= 1'b0;
          if (fall) begin
            state_reg   <= IDLE;
            rep_cnt_reg <= 16'd0;
          end else begin
            case (state_reg)
              IDLE: begin
                if (rise) begin
                  rep_reg     <= 1'b1;
                  rep_cnt_reg <= 16'd0;
                  state_reg   <= rep_en[gi] ? DELAY : HELD;
                end
              end
              DELAY: begin
                if (!rep_en[gi]) begin
                  state_reg   <= HELD;
                  rep_cnt_reg <= 16'd0;
                end else if (rep_cnt_reg == DELAY_LAST) begin
                  rep_reg     <= 1'b1;
                  rep_cnt_reg <= 16'd0;
                  state_reg   <= REPEAT;
                end else if (rep_cnt_reg != CNT_MAX) begin
                  rep_cnt_reg <= rep_cnt_reg + 16'd1;
                end
              end
              REPEAT: begin
                if (!rep_en[gi]) begin
                  state_reg   <= HELD;
                  rep_cnt_reg <= 16'd0;
                end else if (rep_cnt_reg == RATE_LAST) begin
                  rep_reg     <= 1'b1;
                  rep_cnt_reg <= 16'd0;
                end else if (rep_cnt_reg != CNT_MAX) begin
                  rep_cnt_reg <= rep_cnt_reg + 16'd1;
                end
              end
              HELD: begin
                rep_cnt_reg <= 16'd0;
              end
              default: begin
                state_reg   <= IDLE;
                rep_cnt_reg <= 16'd0;
              end
            endcase
          end
        end
      end

      assign btn_level[gi]   = level_reg;
      assign btn_press[gi]   = press_reg;
      assign btn_release[gi] = release_reg;
      assign btn_rep[gi]     = rep_reg;
    end
  endgenerate

  assign any_press = |btn_press;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus randomized bouncing buttons,
// all checked cycle by cycle against a sample-window / timestamp reference model.
module tb_btn_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 32;
  localparam int RR  = 8;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] rep_en;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic [3:0] btn_rep;
  logic       any_press;

  btn_conditioner #(
    .DEB_CYCLES(DEB),
    .REP_DELAY (RD),
    .REP_RATE  (RR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .rep_en     (rep_en),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_rep    (btn_rep),
    .any_press  (any_press)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: raw input history (newest first); a level flips once the
  // last DEB synchronized samples (raw delayed by two edges) all disagree with it.
  logic [3:0] raw_hist[$];
  logic [3:0] m_level = '0;
  logic [3:0] m_press = '0;
  logic [3:0] m_rel   = '0;
  logic [3:0] m_rep   = '0;
  int         cyc = 0;
  int         press_t[4];
  bit         alive[4];

  function automatic logic [3:0] raw_at(input int idx);
    if (idx < raw_hist.size()) return raw_hist[idx];
    return 4'hF;
  endfunction

  task automatic model_edge(input logic [3:0] b_in, input logic [3:0] en_in, input logic r_in);
    cyc++;
    if (r_in) begin
      raw_hist.delete();
      m_level = '0; m_press = '0; m_rel = '0; m_rep = '0;
      for (int b = 0; b < 4; b++) alive[b] = 1'b0;
      return;
    end
    raw_hist.push_front(b_in);
    while (raw_hist.size() > DEB + 4) void'(raw_hist.pop_back());
    for (int b = 0; b < 4; b++) begin
      logic flip;
      logic [3:0] r;
      int d;
      flip = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        r = raw_at(2 + j);
        if (!r[b] == m_level[b]) flip = 1'b0;
      end
      m_press[b] = 1'b0; m_rel[b] = 1'b0; m_rep[b] = 1'b0;
      if (flip) begin
        m_level[b] = !m_level[b];
        if (m_level[b]) m_press[b] = 1'b1;
        else m_rel[b] = 1'b1;
      end
      if (flip && !m_level[b]) begin
        alive[b] = 1'b0;
      end else if (flip) begin
        m_rep[b]   = 1'b1;
        press_t[b] = cyc;
        alive[b]   = en_in[b];
      end else if (alive[b]) begin
        if (!en_in[b]) begin
          alive[b] = 1'b0;
        end else begin
          d = cyc - press_t[b];
          if (d == RD || (d > RD && (d - RD) % RR == 0)) m_rep[b] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(btn, rep_en, rst);
    #1;
    check_val("level",   32'(btn_level),   32'(m_level));
    check_val("press",   32'(btn_press),   32'(m_press));
    check_val("release", 32'(btn_release), 32'(m_rel));
    check_val("rep",     32'(btn_rep),     32'(m_rep));
    check_val("any",     32'(any_press),   32'(|m_press));
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int cnt;
    int first;
    logic [3:0] act;
    logic [3:0] val;
    int any_cnt;
    int rate;

    rst = 1'b1; btn = 4'hF; rep_en = 4'hF;
    settle(2);
    check_val("rst_level", 32'(btn_level), 32'h0);
    check_val("rst_pulses", 32'({btn_press, btn_release, btn_rep, any_press}), 32'h0);
    $display("reset done checks=%0d", checks);

    // All buttons held low from the first edge after reset.
    rst = 1'b0; btn = 4'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("all_pre_level", 32'(btn_level), 32'h0);
    end
    step();
    check_val("all_level", 32'(btn_level), 32'hF);
    check_val("all_press", 32'(btn_press), 32'hF);
    check_val("all_rep",   32'(btn_rep),   32'hF);
    check_val("all_any",   32'(any_press), 32'h1);
    step();
    check_val("all_press_off", 32'(btn_press), 32'h0);
    btn = 4'hF; settle(10);
    $display("all-press done checks=%0d", checks);

    // Bounce on bit 1: three low samples, then a real press.
    btn = 4'b1101; settle(3);
    btn = 4'hF;
    act = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      act |= btn_level | btn_press | btn_release | btn_rep;
    end
    check_val("bounce_quiet", 32'(act), 32'h0);
    btn = 4'b1101;
    settle(5);
    check_val("b1_pre", 32'(btn_level[1]), 32'h0);
    step();
    check_val("b1_level", 32'(btn_level[1]), 32'h1);
    btn = 4'hF; settle(10);
    $display("bounce done checks=%0d", checks);

    // Auto-repeat on bit 2.
    rep_en = 4'hF; btn = 4'b1011;
    settle(5);
    step();
    check_val("b2_press", 32'(btn_press[2]), 32'h1);
    cnt = 0; first = -1;
    for (int k = 1; k < 100; k++) begin
      step();
      if (btn_rep[2]) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    check_val("b2_rep_first", 32'(first), 32'(RD));
    check_val("b2_rep_count", 32'(cnt), 32'(1 + (99 - RD) / RR));
    btn = 4'hF;
    act = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      act |= btn_release;
    end
    check_val("b2_rel_early", 32'(act), 32'h0);
    step();
    check_val("b2_release", 32'(btn_release), 32'b0100);
    settle(4);
    $display("repeat done checks=%0d", checks);

    // Bit 3 with repeat disabled, then disabled mid-run.
    rep_en = 4'b0111; btn = 4'b0111;
    cnt = 0;
    for (int i = 0; i < 70; i++) begin
      step();
      if (btn_rep[3]) cnt++;
    end
    check_val("b3_norep_count", 32'(cnt), 32'h1);
    btn = 4'hF; settle(10);
    rep_en = 4'hF; btn = 4'b0111;
    settle(5);
    step();
    check_val("b3_press", 32'(btn_press[3]), 32'h1);
    cnt = 0;
    for (int k = 1; k <= 80; k++) begin
      if (k == 35) rep_en[3] = 1'b0;
      step();
      if (btn_rep[3]) cnt++;
    end
    check_val("b3_cut_count", 32'(cnt), 32'h1);
    rep_en = 4'hF; btn = 4'hF; settle(10);
    $display("rep-enable done checks=%0d", checks);

    // Reset while bit 0 is repeating; the still-held button becomes a new press.
    btn = 4'b1110; settle(6 + 45);
    rst = 1'b1;
    step();
    check_val("rst_mid_out", 32'({btn_level, btn_press, btn_release, btn_rep, any_press}), 32'h0);
    rst = 1'b0;
    act = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      act |= btn_press | btn_rep;
    end
    check_val("rst_mid_quiet", 32'(act), 32'h0);
    step();
    check_val("rst_mid_press", 32'(btn_press), 32'b0001);
    btn = 4'hF; settle(10);
    $display("reset-mid done checks=%0d", checks);

    // Simultaneous presses on bits 0 and 2.
    btn = 4'b1010;
    cnt = 0; any_cnt = 0; val = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (btn_press != 4'h0) begin cnt++; val = btn_press; end
      if (any_press) any_cnt++;
    end
    check_val("dual_cycles", 32'(cnt), 32'h1);
    check_val("dual_value",  32'(val), 32'b0101);
    check_val("dual_any",    32'(any_cnt), 32'h1);
    btn = 4'hF; settle(10);
    $display("simultaneous done checks=%0d", checks);

    // Randomized bouncing buttons, enable toggles and occasional resets.
    for (int seg = 0; seg < 8; seg++) begin
      rate = $urandom_range(3, 60);
      for (int i = 0; i < 500; i++) begin
        for (int b = 0; b < 4; b++) begin
          if ($urandom_range(0, rate - 1) == 0) btn[b] = ~btn[b];
          if ($urandom_range(0, 149) == 0) rep_en[b] = ~rep_en[b];
        end
        rst = ($urandom_range(0, 799) == 0);
        step();
      end
      rst = 1'b0;
      $display("random segment %0d rate=%0d checks=%0d", seg, rate, checks);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
